// File: rtl/cs_puf_pkg.sv
// Shared definitions for the CS-PUF permutation selector: FSM states and the
// factorial table used by the Lehmer unranking datapath.
package cs_puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    PICK,
    STREAM,
    LASTC,
    FINISH
  } state_t;

  function automatic logic [31:0] fact(input int n);
    logic [31:0] f;
    f = 32'd1;
    for (int i = 2; i <= n; i++) f = f * 32'(i);
    return f;
  endfunction

  // Entries 13..15 pad the table so a 4-bit index taken from k-1 never leaves it
  localparam logic [31:0] FACT [16] = '{
    fact(0), fact(1), fact(2), fact(3), fact(4), fact(5), fact(6),
    fact(7), fact(8), fact(9), fact(10), fact(11), fact(12),
    32'd0, 32'd0, 32'd0
  };

endpackage

// File: rtl/permut_pool.sv
// Pool of not-yet-used element indices; a pick removes the addressed entry
// and closes the gap by shifting the higher entries down.
module permut_pool #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clear,
  input  logic             pick,
  input  logic [IDX_W-1:0] digit,
  output logic [IDX_W-1:0] picked
);

  logic [IDX_W-1:0] pool [N];

  assign picked = pool[digit];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < N; i++) pool[i] <= IDX_W'(i);
    end else if (clear) begin
      for (int i = 0; i < N; i++) pool[i] <= IDX_W'(i);
    end else if (pick) begin
      for (int i = 0; i < N - 1; i++) begin
        if (IDX_W'(i) >= digit) pool[i] <= pool[i + 1];
      end
    end
  end

endmodule

// File: rtl/permut_sel_lehmer.sv
// Maps a selector rank to the matching lexicographic permutation via Lehmer
// unranking, streams it one index per cycle, then enables the sense amplifiers.
module permut_sel_lehmer
  import cs_puf_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N),
  parameter int SEL_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             ready,
  output logic             sel_sat,
  output logic             init,
  output logic             perm_valid,
  output logic [IDX_W-1:0] perm_idx,
  output logic             amp_enable,
  output logic [N-1:0]     cout
);

  localparam int KW = $clog2(N + 1);
  localparam logic [31:0] MAX_RANK = FACT[N] - 32'd1;
  localparam logic [N-1:0] ONE = {{(N - 1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [SEL_W-1:0] rem;
  logic [KW-1:0]    k;
  logic [IDX_W-1:0] digit, step, picked, pick_pos;
  logic [IDX_W-1:0] perm [N];
  logic [3:0]       fact_idx;
  logic [31:0]      fact_k;
  logic             ge, sel_over, abort;

  assign fact_idx = 4'(k) - 4'd1;
  assign fact_k   = FACT[fact_idx];
  assign ge       = {{(32 - SEL_W){1'b0}}, rem} >= fact_k;
  assign sel_over = {{(32 - SEL_W){1'b0}}, sel} > MAX_RANK;
  assign abort    = !en && (state != IDLE);
  assign pick_pos = IDX_W'(KW'(N) - k);

  assign init       = (state == IDLE);
  assign perm_valid = (state == STREAM);
  assign amp_enable = (state == FINISH);
  assign perm_idx   = perm[step];

  permut_pool #(.N(N), .IDX_W(IDX_W)) u_pool (
    .clk    (clk),
    .res    (res),
    .clear  (state == LOAD),
    .pick   ((state == PICK) && !abort),
    .digit  (digit),
    .picked (picked)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = LOAD;
      LOAD:    state_n = DIV;
      DIV:     if (!ge) state_n = PICK;
      PICK:    state_n = (k == KW'(1)) ? STREAM : DIV;
      STREAM:  if (step == IDX_W'(N - 1)) state_n = LASTC;
      LASTC:   state_n = FINISH;
      FINISH:  state_n = FINISH;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  // Dropping en freezes the datapath; cout and sel_sat survive until the next LOAD
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= IDLE;
      rem     <= '0;
      k       <= '0;
      digit   <= '0;
      step    <= '0;
      ready   <= 1'b0;
      sel_sat <= 1'b0;
      cout    <= '0;
      for (int i = 0; i < N; i++) perm[i] <= IDX_W'(i);
    end else begin
      state <= state_n;
      if (abort) begin
        ready <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            rem     <= sel_over ? MAX_RANK[SEL_W-1:0] : sel;
            sel_sat <= sel_over;
            k       <= KW'(N);
            digit   <= '0;
            step    <= '0;
            cout    <= '0;
            ready   <= 1'b0;
          end
          DIV: begin
            if (ge) begin
              rem   <= rem - fact_k[SEL_W-1:0];
              digit <= digit + 1'b1;
            end
          end
          PICK: begin
            perm[pick_pos] <= picked;
            digit          <= '0;
            k              <= k - 1'b1;
            if (k == KW'(1)) ready <= 1'b1;
          end
          STREAM: begin
            cout <= cout | (ONE << perm[step]);
            step <= step + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_permut_sel_lehmer.sv
// Directed bench for permut_sel_lehmer: a Lehmer model predicts each stream,
// a scoreboard queue holds the expected beats until the DUT emits them.
module tb_permut_sel_lehmer;

  localparam int N = 8;
  localparam int IDX_W = 3;
  localparam int SEL_W = 16;

  logic             clk, res, en;
  logic [SEL_W-1:0] sel;
  logic             ready, sel_sat, init, perm_valid, amp_enable;
  logic [IDX_W-1:0] perm_idx;
  logic [N-1:0]     cout;

  int vectors = 0;
  int miscompares = 0;
  int exp_idx[$];
  int exp_mask[$];

  permut_sel_lehmer #(.N(N), .IDX_W(IDX_W), .SEL_W(SEL_W)) dut (
    .clk        (clk),
    .res        (res),
    .en         (en),
    .sel        (sel),
    .ready      (ready),
    .sel_sat    (sel_sat),
    .init       (init),
    .perm_valid (perm_valid),
    .perm_idx   (perm_idx),
    .amp_enable (amp_enable),
    .cout       (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int fact_m(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Division-based unranking; latency counted from the LOAD cycle to ready
  task automatic predict(input int s, output int lat, output bit sat);
    int pool[$];
    int r, f, d, mask;
    pool = {};
    for (int i = 0; i < N; i++) pool.push_back(i);
    sat  = (s > fact_m(N) - 1);
    r    = sat ? fact_m(N) - 1 : s;
    lat  = 1;
    mask = 0;
    for (int kk = N; kk >= 1; kk--) begin
      f = fact_m(kk - 1);
      d = r / f;
      r = r % f;
      lat += d + 2;
      exp_idx.push_back(pool[d]);
      exp_mask.push_back(mask);
      mask |= (1 << pool[d]);
      pool.delete(d);
    end
  endtask

  task automatic apply_stimulus(input int s);
    int lat, cyc, guard, ei, em;
    bit sat;
    predict(s, lat, sat);
    @(negedge clk);
    sel = SEL_W'(s);
    en  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready && cyc < 200);
    check_output($sformatf("sel%0d_ready", s), 32'(ready), 32'd1);
    if (ready) check_output($sformatf("sel%0d_latency", s), 32'(cyc - 1), 32'(lat));
    guard = 0;
    while (exp_idx.size() > 0 && guard < 3 * N) begin
      if (perm_valid) begin
        ei = exp_idx.pop_front();
        em = exp_mask.pop_front();
        check_output($sformatf("sel%0d_idx_beat%0d", s, N - 1 - exp_idx.size()), 32'(perm_idx), 32'(ei));
        check_output($sformatf("sel%0d_cout_beat%0d", s, N - 1 - exp_idx.size()), 32'(cout), 32'(em));
      end
      @(negedge clk);
      guard++;
    end
    if (exp_idx.size() != 0) begin
      check_output($sformatf("sel%0d_beats_left", s), 32'(exp_idx.size()), 32'd0);
      exp_idx = {};
      exp_mask = {};
    end
    check_output($sformatf("sel%0d_lastc_valid", s), 32'(perm_valid), 32'd0);
    check_output($sformatf("sel%0d_lastc_amp", s), 32'(amp_enable), 32'd0);
    check_output($sformatf("sel%0d_final_cout", s), 32'(cout), 32'hFF);
    @(negedge clk);
    check_output($sformatf("sel%0d_finish_amp", s), 32'(amp_enable), 32'd1);
    check_output($sformatf("sel%0d_finish_ready", s), 32'(ready), 32'd1);
    check_output($sformatf("sel%0d_sel_sat", s), 32'(sel_sat), 32'(sat));
    en = 1'b0;
    @(negedge clk);
    check_output($sformatf("sel%0d_idle_init", s), 32'(init), 32'd1);
    check_output($sformatf("sel%0d_idle_ready", s), 32'(ready), 32'd0);
    check_output($sformatf("sel%0d_idle_amp", s), 32'(amp_enable), 32'd0);
    check_output($sformatf("sel%0d_idle_cout_hold", s), 32'(cout), 32'hFF);
  endtask

  initial begin
    bit amp_seen;
    int wait_cyc;
    res = 1'b1;
    en  = 1'b0;
    sel = '0;
    repeat (2) @(negedge clk);
    check_output("rst_ready", 32'(ready), 32'd0);
    check_output("rst_sel_sat", 32'(sel_sat), 32'd0);
    check_output("rst_init", 32'(init), 32'd1);
    check_output("rst_perm_valid", 32'(perm_valid), 32'd0);
    check_output("rst_perm_idx", 32'(perm_idx), 32'd0);
    check_output("rst_amp", 32'(amp_enable), 32'd0);
    check_output("rst_cout", 32'(cout), 32'd0);
    res = 1'b0;

    apply_stimulus(0);
    apply_stimulus(1);
    apply_stimulus(40319);
    apply_stimulus(65535);
    apply_stimulus(1000);
    apply_stimulus(int'($urandom_range(40319, 0)));
    apply_stimulus(int'($urandom_range(40319, 0)));

    $display("[TB] abort during DIV");
    @(negedge clk);
    sel = 16'd40319;
    en  = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_output("abort_init", 32'(init), 32'd1);
    check_output("abort_ready", 32'(ready), 32'd0);
    check_output("abort_valid", 32'(perm_valid), 32'd0);
    amp_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      amp_seen |= amp_enable;
    end
    check_output("abort_amp_never", 32'(amp_seen), 32'd0);
    apply_stimulus(0);

    $display("[TB] reset during STREAM");
    @(negedge clk);
    sel = 16'd5;
    en  = 1'b1;
    wait_cyc = 0;
    while (!perm_valid && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_output("rst_stream_reached", 32'(perm_valid), 32'd1);
    repeat (3) @(negedge clk);
    res = 1'b1;
    en  = 1'b0;
    #1;
    check_output("rst_stream_cout", 32'(cout), 32'd0);
    check_output("rst_stream_valid", 32'(perm_valid), 32'd0);
    check_output("rst_stream_init", 32'(init), 32'd1);
    check_output("rst_stream_ready", 32'(ready), 32'd0);
    @(negedge clk);
    res = 1'b0;
    amp_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      amp_seen |= amp_enable;
    end
    check_output("rst_stream_amp_never", 32'(amp_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
